hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the in-order integer pipeline, replacing the fixed three-stage stall checker. It tracks in-flight register writes in a DEPTH-entry shift scoreboard between decode and write-back. Each cycle it decides whether the decode-stage instruction issues, stalls, or is flushed, and which operand source each read port takes. It also keeps a saturating stall counter for performance monitoring.

## Interface
- NREGS, 32, architectural register count; register 0 is hard-wired zero.
- RW, $clog2(NREGS), register index width.
- DEPTH, 3, scoreboard entries after decode (EX=0, MEM=1, WB=DEPTH-1).
- LOAD_STAGE, 1, first entry index where load data is forwardable.
- SW, $clog2(DEPTH+1), forwarding select width.
- CW, 16, stall counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt  in  RW  source register indices.
- id_use_rs, id_use_rt  in  1  instruction reads that source.
- id_wr_en  in  1  instruction writes a register.
- id_wr_reg  in  RW  destination index.
- id_is_load  in  1  destination is produced by memory read.
- flush  in  1  taken branch resolved in decode; kill the decode instruction.
- stall  out  1  hold PC and IF/ID, insert bubble.
- issue  out  1  decode instruction enters entry 0 this cycle.
- fwd_rs, fwd_rt  out  SW  0 = register file, k+1 = value from entry k.
- stall_cnt  out  CW  saturating count of stall cycles.

## Operation
- Each entry holds valid, wr_en, reg, and is_load.
- On every clock edge, entry k moves to entry k+1, and entry DEPTH-1 retires.
- Entry 0 loads the decode instruction when issue=1; otherwise it loads a bubble (valid=0).
- Source match: id_use_x=1, index != 0, and some entry has valid, wr_en, and reg equal to the index. Only the youngest (lowest k) match counts.
- An entry is ready when is_load=0, or when k >= LOAD_STAGE.
- Matched and ready: fwd_x = k+1. No match: fwd_x = 0.
- Matched and not ready: raise the hazard for that source.
- stall = id_valid & ~flush & (hazard_rs | hazard_rt).
- issue = id_valid & ~flush & ~stall.
- flush has priority over stall: the killed instruction never enters the scoreboard, and stall=0.
- When id_valid=0, fwd outputs still reflect id_rs/id_rt, but stall=0 and issue=0.
- stall_cnt increments on each cycle with stall=1 and holds at 2^CW-1.
- A write to register 0 is entered, but it never matches.

## Timing
- stall, issue, and fwd_* are combinational from the id_* inputs and the registered scoreboard, with zero-cycle latency.
- The scoreboard and stall_cnt update on the rising edge of clk.
- Load-use with LOAD_STAGE=1 costs exactly one stall cycle. The next cycle forwards from entry 1 (fwd=2).
- Reset asserted at any time clears every entry valid bit and sets stall_cnt to 0, so outputs become stall=0 and fwd=0. issue follows the inputs.
- Deassertion of rst_n is synchronised externally, so the first edge after release is a normal shift.
- Back-to-back stalls continue until the producing load reaches LOAD_STAGE; bubbles fill entry 0 meanwhile.

## Configuration
- HAZARD_FWD_EN defined: forwarding behaves as described.
- HAZARD_FWD_EN undefined: fwd_rs and fwd_rt are tied to 0, and any match of any age raises the hazard. The pipeline stalls until the producer retires from entry DEPTH-1, i.e. the register file is written on that edge and read afterwards.

## Structure
- The shared package holds:
  - the scoreboard entry struct {valid, wr_en, reg, is_load};
  - the default NREGS and DEPTH constants;
  - the FWD_REGFILE = 0 select constant.
- One sub-module, hazard_match: a combinational youngest-match priority encoder over the DEPTH entries. It is instantiated once per source port and returns hit, index k, and ready.
- The top level contains the shift register, stall/issue logic, and the counter.

## Test plan
- ADD r3 issues, then a dependent ADD reads r3 on the next cycle: stall=0, fwd_rs=1. The cycle after that, an independent reader of r3 sees fwd=2.
- LW r5 issues, then ADD reads r5: stall=1 for one cycle and stall_cnt=1. On the next cycle stall=0, fwd=2, issue=1.
- Two writers of r7 in entries 0 and 2: a reader gets fwd=1 (youngest wins).
- flush=1 together with a load-use hazard: stall=0 and issue=0. On the next cycle entry 0 is a bubble.
- A reader of r0 while the scoreboard holds an r0 write: fwd=0, stall=0.
- Build without HAZARD_FWD_EN and issue ADD r2 followed by a reader of r2: stall=1 for 3 cycles (DEPTH), then issue with fwd=0.
- Assert rst_n=0 mid-stall: stall drops to 0 immediately and stall_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Entry register field is sized for the largest supported register file.
package hazard_scoreboard_pkg;

    localparam int NREGS_DEF   = 32;
    localparam int DEPTH_DEF   = 3;
    localparam int FWD_REGFILE = 0;
    // Register field width in an entry; NREGS up to 256 fits without changes.
    localparam int RW_MAX      = 8;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [RW_MAX-1:0] wr_reg;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source port over the scoreboard entries.
// Returns whether a live writer of src exists, its entry index and whether its data is forwardable.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_STAGE = 1,
    parameter int RW         = 5,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic          use_src,
    input  logic [RW-1:0] src,
    input  sb_entry_t     entries [DEPTH],
    output logic          hit,
    output logic [SW-1:0] idx,
    output logic          ready
);

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        ready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_src && (src != '0) && entries[k].valid && entries[k].wr_en &&
                (entries[k].wr_reg == RW_MAX'(src))) begin
                hit   = 1'b1;
                idx   = SW'(k);
                ready = !entries[k].is_load || (k >= LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detection and forwarding select over a DEPTH-entry shift scoreboard.
// Define HAZARD_FWD_EN to enable forwarding; without it readers stall until the producer retires.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int RW         = $clog2(NREGS),
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = $clog2(DEPTH + 1),
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr_en,
    input  logic [RW-1:0] id_wr_reg,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [SW-1:0] fwd_rs,
    output logic [SW-1:0] fwd_rt,
    output logic [CW-1:0] stall_cnt
);

    sb_entry_t     sb_q [DEPTH];
    sb_entry_t     sb_d [DEPTH];
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] stall_cnt_d;

    logic          hit_rs, hit_rt;
    logic          rdy_rs, rdy_rt;
    logic [SW-1:0] idx_rs, idx_rt;
    logic          hazard_rs, hazard_rt;

    hazard_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .RW(RW), .SW(SW)) u_match_rs (
        .use_src (id_use_rs),
        .src     (id_rs),
        .entries (sb_q),
        .hit     (hit_rs),
        .idx     (idx_rs),
        .ready   (rdy_rs)
    );

    hazard_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .RW(RW), .SW(SW)) u_match_rt (
        .use_src (id_use_rt),
        .src     (id_rt),
        .entries (sb_q),
        .hit     (hit_rt),
        .idx     (idx_rt),
        .ready   (rdy_rt)
    );

`ifdef HAZARD_FWD_EN
    assign hazard_rs = hit_rs && !rdy_rs;
    assign hazard_rt = hit_rt && !rdy_rt;
    assign fwd_rs    = hit_rs ? SW'(idx_rs + 1'b1) : SW'(FWD_REGFILE);
    assign fwd_rt    = hit_rt ? SW'(idx_rt + 1'b1) : SW'(FWD_REGFILE);
`else
    // Without forwarding any in-flight writer blocks the read until it has retired.
    logic unused_match;
    assign unused_match = ^{idx_rs, idx_rt, rdy_rs, rdy_rt};
    assign hazard_rs    = hit_rs;
    assign hazard_rt    = hit_rt;
    assign fwd_rs       = SW'(FWD_REGFILE);
    assign fwd_rt       = SW'(FWD_REGFILE);
`endif

    // A flushed instruction neither stalls nor issues.
    assign stall     = id_valid && !flush && (hazard_rs || hazard_rt);
    assign issue     = id_valid && !flush && !stall;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        sb_d[0] = '0;
        if (issue) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].wr_en   = id_wr_en;
            sb_d[0].wr_reg  = RW_MAX'(id_wr_reg);
            sb_d[0].is_load = id_is_load;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a reference scoreboard model predicts each cycle's
// stall/issue/fwd/stall_cnt, expectations are queued at drive time and popped at the falling edge.
module tb_hazard_scoreboard;

    localparam int NREGS      = 32;
    localparam int RW         = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int SW         = 2;
    localparam int CW         = 16;
    localparam int GUARD      = 40;
`ifdef HAZARD_FWD_EN
    localparam int LU_STALLS  = 1;
    localparam int ALU_STALLS = 0;
`else
    localparam int LU_STALLS  = DEPTH;
    localparam int ALU_STALLS = DEPTH;
`endif

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_wr_reg;
    logic          id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;
    logic          stall, issue;
    logic [SW-1:0] fwd_rs, fwd_rt;
    logic [CW-1:0] stall_cnt;

    hazard_scoreboard #(
        .NREGS(NREGS), .RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .issue      (issue),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          urs;
        logic          urt;
        logic          wr;
        logic [RW-1:0] wd;
        logic          ld;
        logic          fl;
    } stim_t;

    typedef struct packed {
        logic          stall;
        logic          issue;
        logic [SW-1:0] frs;
        logic [SW-1:0] frt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    logic          m_v [DEPTH];
    logic          m_w [DEPTH];
    logic          m_l [DEPTH];
    logic [RW-1:0] m_r [DEPTH];
    logic [CW-1:0] m_cnt;
    logic          p_issue, p_stall;
    stim_t         p_s;

    function automatic stim_t alu(input int wd, input int rs, input int rt);
        stim_t s;
        s     = '0;
        s.v   = 1'b1;
        s.wr  = 1'b1;
        s.wd  = RW'(wd);
        s.rs  = RW'(rs);
        s.rt  = RW'(rt);
        s.urs = 1'b1;
        s.urt = 1'b1;
        return s;
    endfunction

    function automatic stim_t lw(input int wd, input int rs);
        stim_t s;
        s     = '0;
        s.v   = 1'b1;
        s.wr  = 1'b1;
        s.ld  = 1'b1;
        s.wd  = RW'(wd);
        s.rs  = RW'(rs);
        s.urs = 1'b1;
        return s;
    endfunction

    function automatic stim_t nop();
        return '0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 1'b0; m_w[k] = 1'b0; m_l[k] = 1'b0; m_r[k] = '0;
        end
        m_cnt = '0;
    endtask

    // Reference lookup: walk from the youngest entry and stop at the first live writer.
    task automatic model_src(input logic use_s, input logic [RW-1:0] s,
                             output logic haz, output logic [SW-1:0] f);
        logic found;
        haz   = 1'b0;
        f     = '0;
        found = 1'b0;
        if (use_s && s != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && m_v[k] && m_w[k] && m_r[k] == s) begin
                    found = 1'b1;
`ifdef HAZARD_FWD_EN
                    if (m_l[k] && k < LOAD_STAGE) haz = 1'b1;
                    else f = SW'(k + 1);
`else
                    haz = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic drive(input stim_t s);
        logic hz_rs, hz_rt;
        logic [SW-1:0] f_rs, f_rt;
        exp_t e;
        id_valid = s.v;  id_rs = s.rs;  id_rt = s.rt;
        id_use_rs = s.urs; id_use_rt = s.urt;
        id_wr_en = s.wr; id_wr_reg = s.wd; id_is_load = s.ld; flush = s.fl;
        model_src(s.urs, s.rs, hz_rs, f_rs);
        model_src(s.urt, s.rt, hz_rt, f_rt);
        e.stall = s.v && !s.fl && (hz_rs || hz_rt);
        e.issue = s.v && !s.fl && !e.stall;
        e.frs   = f_rs;
        e.frt   = f_rt;
        e.cnt   = m_cnt;
        p_issue = e.issue;
        p_stall = e.stall;
        p_s     = s;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_l[k] = m_l[k-1]; m_r[k] = m_r[k-1];
            end
            m_v[0] = p_issue;
            m_w[0] = p_issue && p_s.wr;
            m_l[0] = p_issue && p_s.ld;
            m_r[0] = p_issue ? p_s.wd : '0;
            if (p_stall && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        drive(alu(3, 1, 2));
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_sb0: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        checks++;
        if ({stall, fwd_rs, fwd_rt, stall_cnt} !== '0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want 0 1 0 0 0",
                     stall, issue, fwd_rs, fwd_rt, stall_cnt);
        end
        step();
        // Still in reset: the issued ADD r3 must not have been captured.
        drive(alu(4, 3, 3));
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_sb1: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        rst_n = 1'b1;
        step();
        drive(nop());
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_sb2: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        step();
    endtask

    task automatic test_fwd_alu();
        stim_t seq[$];
        exp_t e, o;
        int i = 0, guard = 0, n_stall = 0;
        seq.push_back(alu(3, 1, 2)); seq.push_back(alu(4, 3, 0)); seq.push_back(alu(6, 3, 3));
        seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            n_stall += int'(stall);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fwd_alu[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL fwd_alu_timeout: got %0d rows done, want %0d", i, seq.size());
        end
        checks++;
        if (n_stall != ALU_STALLS) begin
            errors++;
            $display("FAIL fwd_alu_stalls: got %0d, want %0d", n_stall, ALU_STALLS);
        end
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        exp_t e, o;
        int i = 0, guard = 0, n_stall = 0;
        seq.push_back(lw(5, 1)); seq.push_back(alu(8, 5, 2));
        seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            n_stall += int'(stall);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL load_use_timeout: got %0d rows done, want %0d", i, seq.size());
        end
        checks++;
        if (n_stall != LU_STALLS) begin
            errors++;
            $display("FAIL load_use_stalls: got %0d, want %0d", n_stall, LU_STALLS);
        end
    endtask

    task automatic test_youngest();
        stim_t seq[$];
        exp_t e, o;
        int i = 0, guard = 0;
        seq.push_back(alu(7, 1, 2)); seq.push_back(alu(9, 1, 2)); seq.push_back(alu(7, 2, 1));
        seq.push_back(alu(10, 7, 0)); seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL youngest[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
`ifdef HAZARD_FWD_EN
            if (i == 3) begin
                checks++;
                if (fwd_rs !== 2'd1 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL youngest_wins: got fwd_rs=%0d stall=%0b, want 1 0", fwd_rs, stall);
                end
            end
`endif
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL youngest_timeout: got %0d rows done, want %0d", i, seq.size());
        end
    endtask

    task automatic test_flush();
        stim_t seq[$];
        stim_t s;
        exp_t e, o;
        int i = 0, guard = 0;
        s = alu(10, 9, 2);
        s.fl = 1'b1;
        seq.push_back(lw(9, 1)); seq.push_back(s); seq.push_back(alu(11, 10, 9));
        seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flush[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
            if (i == 1) begin
                checks++;
                if (stall !== 1'b0 || issue !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_priority: got stall=%0b issue=%0b, want 0 0", stall, issue);
                end
            end
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL flush_timeout: got %0d rows done, want %0d", i, seq.size());
        end
    endtask

    task automatic test_r0_and_idle();
        stim_t seq[$];
        stim_t s;
        exp_t e, o;
        int i = 0, guard = 0;
        s = alu(13, 12, 0);
        s.v = 1'b0;
        seq.push_back(alu(0, 1, 2)); seq.push_back(alu(12, 0, 0)); seq.push_back(s);
        seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL r0_idle[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
            if (i == 1) begin
                checks++;
                if (fwd_rs !== '0 || fwd_rt !== '0 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL r0_never_matches: got fwd_rs=%0d fwd_rt=%0d stall=%0b, want 0 0 0", fwd_rs, fwd_rt, stall);
                end
            end
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL r0_idle_timeout: got %0d rows done, want %0d", i, seq.size());
        end
    endtask

    task automatic test_back_to_back();
        stim_t seq[$];
        exp_t e, o;
        int i = 0, guard = 0;
        seq.push_back(lw(1, 2)); seq.push_back(lw(2, 1)); seq.push_back(alu(3, 2, 1));
        seq.push_back(nop()); seq.push_back(nop()); seq.push_back(nop());
        while (i < seq.size() && guard < GUARD) begin
            drive(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         i, o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
            end
            step();
            if (!e.stall) i++;
            guard++;
        end
        if (i < seq.size()) begin
            checks++; errors++;
            $display("FAIL back_to_back_timeout: got %0d rows done, want %0d", i, seq.size());
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e, o;
        drive(lw(5, 1));
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL midrst_lw: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        step();
        drive(alu(8, 5, 2));
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e || stall !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stall: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || stall_cnt !== '0 || fwd_rs !== '0 || fwd_rt !== '0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want 0 1 0 0 0",
                     stall, issue, fwd_rs, fwd_rt, stall_cnt);
        end
        model_clear();
        drive(nop());
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL midrst_hold: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        rst_n = 1'b1;
        step();
        drive(alu(8, 5, 2));
        @(negedge clk);
        e = exp_q.pop_front();
        o = {stall, issue, fwd_rs, fwd_rt, stall_cnt};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL midrst_after: got stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d, want stall=%0b issue=%0b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.stall, o.issue, o.frs, o.frt, o.cnt, e.stall, e.issue, e.frs, e.frt, e.cnt);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0; flush = 1'b0;
        model_clear();
        p_issue = 1'b0;
        p_stall = 1'b0;
        p_s     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_youngest();
        test_flush();
        test_r0_and_idle();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
